// File: rtl/slice_sequencer.sv
// slice_sequencer: takes one job (word, base, stride, count, direction) and
// streams count fixed-width slices of the word over a valid/ready handshake.
// Slice indices wrap modulo DATA_W in both directions.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a job; in_ready=1, out_valid=0
// EMIT  | presenting a slice; out_valid=1, busy=1, advances on out_ready
module slice_sequencer #(
    parameter int DATA_W  = 8,
    parameter int SLICE_W = 4,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [IDX_W-1:0]   in_base,
    input  logic [IDX_W-1:0]   in_stride,
    input  logic [CNT_W-1:0]   in_count,
    input  logic               in_dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_last,
    output logic               busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  stride_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              dir_q;

    logic              accept;
    logic              start_job;
    logic              advance;
    logic              finish;
    logic [IDX_W-1:0]  next_idx;

    // The word is doubled so a slice that runs off either end reads the
    // wrapped bits straight out of the upper copy; a minus select is taken
    // from the upper copy so its low end never goes below bit 0.
    function automatic logic [SLICE_W-1:0] select_slice(
        input logic [DATA_W-1:0] word,
        input logic [IDX_W-1:0]  idx,
        input logic              dir
    );
        logic [2*DATA_W-1:0] doubled;
        logic [IDX_W:0]      top;
        doubled = {word, word};
        top     = {1'b0, idx} + (IDX_W+1)'(DATA_W);
        if (dir)
            return doubled[top -: SLICE_W];
        else
            return doubled[{1'b0, idx} +: SLICE_W];
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign busy      = (state == EMIT);

    assign accept    = in_valid & in_ready;
    assign start_job = accept && (in_count != '0);
    assign advance   = out_valid & out_ready;
    assign finish    = advance && (remaining_q == CNT_W'(1));
    assign next_idx  = dir_q ? (out_index - stride_q) : (out_index + stride_q);

    // State transitions: a zero-count job is swallowed without leaving IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start_job) state <= EMIT;
                EMIT:    if (finish)    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Job registers: captured on accept, remaining counts down per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
        end else if (start_job) begin
            word_q      <= in_data;
            stride_q    <= in_stride;
            remaining_q <= in_count;
            dir_q       <= in_dir;
        end else if (advance) begin
            remaining_q <= remaining_q - CNT_W'(1);
        end
    end

    // Output registers: load the first slice on accept, the next on each
    // non-final handshake, and hold otherwise so stalls see stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_slice <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (start_job) begin
            out_slice <= select_slice(in_data, in_base, in_dir);
            out_index <= in_base;
            out_last  <= (in_count == CNT_W'(1));
        end else if (advance && !finish) begin
            out_slice <= select_slice(word_q, next_idx, dir_q);
            out_index <= next_idx;
            out_last  <= (remaining_q == CNT_W'(2));
        end
    end

endmodule

// File: doc/slice_sequencer.md
Name: slice_sequencer

Overview:
Streams a sequence of fixed-width indexed part-selects out of a captured data word. Each job is one word plus a base index, a stride, a count and a direction; the block emits one slice per output handshake. It sits between a word producer and a narrow consumer, and drives the slice datapath (+: / -: selects) from an FSM instead of fixed indices. Indices wrap modulo DATA_W, so slices that run past either end of the word rotate around.

Parameters:
DATA_W, 8, width of the captured word; must be a power of 2 and at least SLICE_W.
SLICE_W, 4, width of each emitted slice.
CNT_W, 4, width of the slice-count field, giving up to 2^CNT_W-1 slices per job.
IDX_W, $clog2(DATA_W), derived width of the index fields; not to be overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  job request valid.
in_ready  out  1  block can accept a job; high only in IDLE.
in_data  in  DATA_W  word to slice.
in_base  in  IDX_W  index of the first slice.
in_stride  in  IDX_W  index step between slices.
in_count  in  CNT_W  number of slices to emit.
in_dir  in  1  direction: 0 = plus (bits base+SLICE_W-1..base), base increments by stride; 1 = minus (bits base..base-SLICE_W+1), base decrements by stride.
out_valid  out  1  slice valid.
out_ready  in  1  consumer accepts the slice.
out_slice  out  SLICE_W  slice data, MSB = highest index of the select.
out_index  out  IDX_W  base index of the current slice.
out_last  out  1  current slice is the final slice of the job.
busy  out  1  high whenever the FSM is in EMIT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, out_slice=0, out_index=0, out_last=0, busy=0.
  - The job registers (word, base, stride, remaining count, direction) clear to 0.
- Reset mid-job: the job is abandoned with no further slices. After rst_n rises, the first accepted job starts fresh.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1, busy=1.
- IDLE transitions, on in_valid & in_ready:
  - in_count==0: the job is consumed, nothing is emitted, FSM stays in IDLE.
  - otherwise: latch all job fields, remaining=in_count, go to EMIT.
- Latency: job accepted in cycle N; out_valid=1 with the first slice in cycle N+1.
- Output registers: out_slice, out_index and out_last are registered and hold stable while out_valid=1 and out_ready=0.
- Slice bit mapping: slice bit k = word[(idx + k - (dir ? SLICE_W-1 : 0)) mod DATA_W], for k = 0..SLICE_W-1.
- out_last = (remaining==1).
- EMIT transitions, on out_valid & out_ready:
  - remaining==1: go to IDLE; in_ready rises the next cycle. A new job is never accepted in the same cycle as the last handshake.
  - otherwise: remaining decrements; idx becomes (idx ± stride) mod DATA_W; the next slice is presented the following cycle.
- Throughput: back-to-back slices, one per cycle, while out_ready stays high.
- Index arithmetic: performed in IDX_W bits with natural wrap.
  - stride==0 repeats the same slice count times.
  - stride >= DATA_W cannot occur, because stride is IDX_W bits wide.
- Input changes:
  - in_data and the other job inputs are ignored outside the accept cycle.
  - in_valid high during EMIT has no effect, since in_ready=0.

Test Plan:
1. Reset, then job data=8'b11010101, base=2, stride=0, count=1, dir=0 -> one cycle after accept: out_slice=4'b0101, out_index=2, out_last=1; in_ready=1 the cycle after the handshake.
2. Job data=8'b10101010, base=0, stride=4, count=2, dir=0, out_ready=1 -> slices 1010 (idx 0) then 1010 (idx 4, last) on consecutive cycles.
3. Job data=8'b11110000, base=7, stride=4, count=3, dir=1 -> 1111 (idx 7), 0000 (idx 3), 1111 (idx 7, last); checks minus wrap 3-4 -> 7.
4. Wrap: data=8'b11010101, base=6, dir=0 -> 4'b0111. Same data, base=1, dir=1 -> 4'b0111.
5. Backpressure: in the scenario-2 job, hold out_ready=0 for 3 cycles on the first slice -> out_slice, out_index and out_last stay unchanged and there is no advance; release -> sequence resumes exactly.
6. Drive in_count=0 -> in_ready stays 1 and out_valid never asserts. Start a count=3 job and assert rst_n=0 after the first slice -> all outputs reach their reset values immediately (asynchronously); no further slices after release.
